// File: rtl/param_count_decode.sv
// param_count_decode: parametrised up/down counter with load, wrap/saturate
// mode, low-field decode outputs and a registered wrap pulse plus a
// saturating wrap event counter.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   en        count enable
//   load      parallel load strobe (beats en)
//   load_val  value loaded when load=1
//   dir       1=count up, 0=count down
//   sat       1=saturate at bounds, 0=wrap modulo 2^WIDTH
//   wc_clr    synchronous clear of wrap_cnt (beats a same-edge wrap)
//   count     registered count
//   inv_low   ~count[INV_BITS-1:0]
//   and_low   &count[AND_BITS-1:0]
//   at_bound  count at the bound in the current direction
//   wrap      one-cycle pulse: the previous update wrapped
//   wrap_cnt  wraps since reset/clear, saturating at all-ones
module param_count_decode #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP     = 1,
  parameter int unsigned INV_BITS = 4,
  parameter int unsigned AND_BITS = 2,
  parameter int unsigned WC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                dir,
  input  logic                sat,
  input  logic                wc_clr,
  output logic [WIDTH-1:0]    count,
  output logic [INV_BITS-1:0] inv_low,
  output logic                and_low,
  output logic                at_bound,
  output logic                wrap,
  output logic [WC_WIDTH-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0] CountMax = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] StepW    = WIDTH'(STEP);
  // One extra bit so an overflowing increment / underflowing decrement is visible.
  localparam logic [WIDTH:0]   StepExt  = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   MaxExt   = {1'b0, CountMax};

  logic [WIDTH-1:0]    count_q, count_d;
  logic                wrap_q, wrap_d;
  logic [WC_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [WIDTH:0]      sum;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sum     = {1'b0, count_q} + StepExt;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (dir) begin
        if (sum > MaxExt) begin
          if (sat) begin
            count_d = CountMax;
          end else begin
            count_d = sum[WIDTH-1:0];
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = sum[WIDTH-1:0];
        end
      end else begin
        if (StepExt > {1'b0, count_q}) begin
          if (sat) begin
            count_d = '0;
          end else begin
            count_d = count_q - StepW;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - StepW;
        end
      end
    end
  end

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wc_clr) begin
      wrap_cnt_d = '0;
    end else if (wrap_d && !(&wrap_cnt_q)) begin
      wrap_cnt_d = wrap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign inv_low  = ~count_q[INV_BITS-1:0];
  assign and_low  = &count_q[AND_BITS-1:0];
  assign at_bound = dir ? (count_q == CountMax) : (count_q == '0);

endmodule

// File: tb/tb_param_count_decode.sv
module tb_param_count_decode;

  logic       clk = 1'b0;
  logic       rst, en, load, dir, sat, wc_clr;
  logic [7:0] load_val;

  // u_a: default parameters. u_b: STEP=3, WC_WIDTH=2.
  logic [7:0] count_a, count_b;
  logic [3:0] inv_a, inv_b;
  logic       and_a, and_b, bound_a, bound_b, wrap_a, wrap_b;
  logic [3:0] wc_a;
  logic [1:0] wc_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       load;
    logic       en;
    logic       dir;
    logic       sat;
    logic       clr;
    logic [7:0] lv;
    logic [7:0] count;
    logic       wrap;
    logic [3:0] wc;
  } step_t;

  typedef struct packed {
    logic [7:0] count;
    logic       wrap;
    logic [3:0] wc;
  } exp_t;

  exp_t sb[$];

  param_count_decode u_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .dir(dir),
    .sat(sat), .wc_clr(wc_clr), .count(count_a), .inv_low(inv_a), .and_low(and_a),
    .at_bound(bound_a), .wrap(wrap_a), .wrap_cnt(wc_a)
  );

  param_count_decode #(.STEP(3), .WC_WIDTH(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .dir(dir),
    .sat(sat), .wc_clr(wc_clr), .count(count_b), .inv_low(inv_b), .and_low(and_b),
    .at_bound(bound_b), .wrap(wrap_b), .wrap_cnt(wc_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic set_in(input step_t s);
    load     = s.load;
    en       = s.en;
    dir      = s.dir;
    sat      = s.sat;
    wc_clr   = s.clr;
    load_val = s.lv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in('0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in('0);
    #2;
    checks += 7;
    if (count_a !== 8'h00) begin errors++; $display("FAIL reset count got %h want 00", count_a); end
    if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset wrap got %b want 0", wrap_a); end
    if (wc_a !== 4'd0) begin errors++; $display("FAIL reset wrap_cnt got %0d want 0", wc_a); end
    if (inv_a !== 4'hF) begin errors++; $display("FAIL reset inv_low got %b want 1111", inv_a); end
    if (and_a !== 1'b0) begin errors++; $display("FAIL reset and_low got %b want 0", and_a); end
    if (bound_a !== 1'b1) begin errors++; $display("FAIL reset at_bound got %b want 1", bound_a); end
    if (count_b !== 8'h00) begin errors++; $display("FAIL reset count_b got %h want 00", count_b); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    exp_t ex;
    step_t s;
    do_reset();
    for (int i = 1; i <= 21; i++) begin
      // 20 counting edges, then one hold edge with en=0.
      s = '{load: 1'b0, en: (i <= 20), dir: 1'b1, sat: 1'b0, clr: 1'b0, lv: 8'h00,
            count: 8'((i <= 20) ? i : 20), wrap: 1'b0, wc: 4'd0};
      set_in(s);
      sb.push_back('{s.count, s.wrap, s.wc});
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks += 3;
      if (count_a !== ex.count) begin errors++; $display("FAIL count_up[%0d] count got %h want %h", i, count_a, ex.count); end
      if (wrap_a !== ex.wrap) begin errors++; $display("FAIL count_up[%0d] wrap got %b want %b", i, wrap_a, ex.wrap); end
      if (wc_a !== ex.wc) begin errors++; $display("FAIL count_up[%0d] wrap_cnt got %0d want %0d", i, wc_a, ex.wc); end
      if (i == 3) begin
        checks += 2;
        if (inv_a !== 4'b1100) begin errors++; $display("FAIL decode3 inv_low got %b want 1100", inv_a); end
        if (and_a !== 1'b1) begin errors++; $display("FAIL decode3 and_low got %b want 1", and_a); end
      end
      if (i == 4) begin
        checks += 2;
        if (inv_a !== 4'b1011) begin errors++; $display("FAIL decode4 inv_low got %b want 1011", inv_a); end
        if (and_a !== 1'b0) begin errors++; $display("FAIL decode4 and_low got %b want 0", and_a); end
      end
    end
  endtask

  task automatic test_wrap_up();
    exp_t ex;
    step_t st [4];
    do_reset();
    st[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 8'hFE, 1'b0, 4'd0};
    st[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 4'd0};
    st[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 4'd1};
    st[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 4'd1};
    for (int i = 0; i < 4; i++) begin
      set_in(st[i]);
      sb.push_back('{st[i].count, st[i].wrap, st[i].wc});
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks += 3;
      if (count_a !== ex.count) begin errors++; $display("FAIL wrap_up[%0d] count got %h want %h", i, count_a, ex.count); end
      if (wrap_a !== ex.wrap) begin errors++; $display("FAIL wrap_up[%0d] wrap got %b want %b", i, wrap_a, ex.wrap); end
      if (wc_a !== ex.wc) begin errors++; $display("FAIL wrap_up[%0d] wrap_cnt got %0d want %0d", i, wc_a, ex.wc); end
      if (i == 1) begin
        checks++;
        if (bound_a !== 1'b1) begin errors++; $display("FAIL wrap_up at_bound got %b want 1", bound_a); end
      end
    end
  endtask

  task automatic test_sat_up();
    exp_t ex;
    step_t st [4];
    do_reset();
    st[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFE, 8'hFE, 1'b0, 4'd0};
    for (int i = 1; i < 4; i++) st[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 4'd0};
    for (int i = 0; i < 4; i++) begin
      set_in(st[i]);
      sb.push_back('{st[i].count, st[i].wrap, st[i].wc});
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks += 3;
      if (count_a !== ex.count) begin errors++; $display("FAIL sat_up[%0d] count got %h want %h", i, count_a, ex.count); end
      if (wrap_a !== ex.wrap) begin errors++; $display("FAIL sat_up[%0d] wrap got %b want %b", i, wrap_a, ex.wrap); end
      if (wc_a !== ex.wc) begin errors++; $display("FAIL sat_up[%0d] wrap_cnt got %0d want %0d", i, wc_a, ex.wc); end
    end
    checks++;
    if (bound_a !== 1'b1) begin errors++; $display("FAIL sat_up at_bound got %b want 1", bound_a); end
  endtask

  task automatic test_step3_down();
    exp_t ex;
    step_t st [4];
    do_reset();
    st[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 4'd0};
    st[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b1, 4'd1};
    st[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 4'd1};
    st[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd1};
    for (int i = 0; i < 4; i++) begin
      set_in(st[i]);
      sb.push_back('{st[i].count, st[i].wrap, st[i].wc});
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks += 3;
      if (count_b !== ex.count) begin errors++; $display("FAIL step3_down[%0d] count got %h want %h", i, count_b, ex.count); end
      if (wrap_b !== ex.wrap) begin errors++; $display("FAIL step3_down[%0d] wrap got %b want %b", i, wrap_b, ex.wrap); end
      if ({2'b00, wc_b} !== ex.wc) begin errors++; $display("FAIL step3_down[%0d] wrap_cnt got %0d want %0d", i, wc_b, ex.wc); end
    end
    checks++;
    if (bound_b !== 1'b1) begin errors++; $display("FAIL step3_down at_bound got %b want 1", bound_b); end
  endtask

  task automatic test_wrap_cnt();
    exp_t ex;
    step_t st [13];
    logic [3:0] want [5] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
    do_reset();
    // Five load-01 / count-down-by-3 pairs, each wrapping to FE.
    for (int k = 0; k < 5; k++) begin
      st[2*k]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, (k == 0) ? 4'd0 : want[k-1]};
      st[2*k+1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b1, want[k]};
    end
    // wc_clr on a wrapping edge: that wrap is not counted.
    st[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 4'd3};
    st[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFE, 1'b1, 4'd0};
    st[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 4'd0};
    for (int i = 0; i < 13; i++) begin
      set_in(st[i]);
      sb.push_back('{st[i].count, st[i].wrap, st[i].wc});
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks += 3;
      if (count_b !== ex.count) begin errors++; $display("FAIL wrap_cnt[%0d] count got %h want %h", i, count_b, ex.count); end
      if (wrap_b !== ex.wrap) begin errors++; $display("FAIL wrap_cnt[%0d] wrap got %b want %b", i, wrap_b, ex.wrap); end
      if ({2'b00, wc_b} !== ex.wc) begin errors++; $display("FAIL wrap_cnt[%0d] wrap_cnt got %0d want %0d", i, wc_b, ex.wc); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t ex;
    step_t st [5];
    do_reset();
    // Alternating direction with STEP=3 from 01 wraps on every edge.
    st[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 4'd0};
    st[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b1, 4'd1};
    st[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 4'd2};
    st[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b1, 4'd3};
    st[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 4'd3};
    for (int i = 0; i < 5; i++) begin
      set_in(st[i]);
      sb.push_back('{st[i].count, st[i].wrap, st[i].wc});
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks += 3;
      if (count_b !== ex.count) begin errors++; $display("FAIL back_to_back[%0d] count got %h want %h", i, count_b, ex.count); end
      if (wrap_b !== ex.wrap) begin errors++; $display("FAIL back_to_back[%0d] wrap got %b want %b", i, wrap_b, ex.wrap); end
      if ({2'b00, wc_b} !== ex.wc) begin errors++; $display("FAIL back_to_back[%0d] wrap_cnt got %0d want %0d", i, wc_b, ex.wc); end
    end
  endtask

  task automatic test_async_reset();
    exp_t ex;
    step_t st [5];
    do_reset();
    st[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 4'd0};
    st[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 4'd1};
    st[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h37, 8'h37, 1'b0, 4'd1};
    st[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 4'd0};
    st[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 4'd0};
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        // Mid-cycle async reset with load and en both active.
        load = 1'b1; en = 1'b1; load_val = 8'hAA;
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (count_a !== 8'h00) begin errors++; $display("FAIL async_rst count got %h want 00", count_a); end
        if (wrap_a !== 1'b0) begin errors++; $display("FAIL async_rst wrap got %b want 0", wrap_a); end
        if (wc_a !== 4'd0) begin errors++; $display("FAIL async_rst wrap_cnt got %0d want 0", wc_a); end
        @(negedge clk);
        rst = 1'b0;
      end
      set_in(st[i]);
      sb.push_back('{st[i].count, st[i].wrap, st[i].wc});
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks += 3;
      if (count_a !== ex.count) begin errors++; $display("FAIL async_rst[%0d] count got %h want %h", i, count_a, ex.count); end
      if (wrap_a !== ex.wrap) begin errors++; $display("FAIL async_rst[%0d] wrap got %b want %b", i, wrap_a, ex.wrap); end
      if (wc_a !== ex.wc) begin errors++; $display("FAIL async_rst[%0d] wrap_cnt got %0d want %0d", i, wc_a, ex.wc); end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_sat_up();
    test_step3_down();
    test_wrap_cnt();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
